// File: rtl/jtpang_objdma_pkg.sv
// jtpang_objdma_pkg: shared state encoding and default copy window for the object DMA
package jtpang_objdma_pkg;
   typedef enum logic [2:0] {IDLE, REQ, COPY, FLUSH, REL} state_t;
   localparam logic [15:0] SRC_BASE_DEF = 16'hE000;
   localparam int          LEN_DEF      = 512;
endpackage

// File: rtl/jtpang_objdma_if.sv
// jtpang_objdma_if: Z80 bus-steal handshake, main-bus read port and object buffer write port
interface jtpang_objdma_if #(parameter int AW = 9);
   logic          busrq_n;
   logic          busak_n;
   logic [15:0]   dma_addr;
   logic          dma_rd;
   logic [7:0]    dma_din;
   logic [AW-1:0] obj_addr;
   logic [7:0]    obj_dout;
   logic          obj_we;
   modport master(output busrq_n, dma_addr, dma_rd, obj_addr, obj_dout, obj_we, input busak_n, dma_din);
   modport slave(input busrq_n, dma_addr, dma_rd, obj_addr, obj_dout, obj_we, output busak_n, dma_din);
endinterface

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: on a start edge, steals the Z80 bus and copies LEN bytes from SRC_BASE
// into the object buffer, reading one byte per cen with a one-cen data pipeline.
module jtpang_objdma
   import jtpang_objdma_pkg::*;
#(
   parameter logic [15:0] SRC_BASE = SRC_BASE_DEF,
   parameter int          LEN      = LEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic            dma_start,
   output logic            busy,
   jtpang_objdma_if.master bus
);
   localparam int AW = $clog2(LEN);

   state_t        st_q, st_d;
   logic          start_q, rise;
   logic          pend_q, pend_d;
   logic [AW-1:0] cnt_q, cnt_d, oaddr_q, oaddr_d;
   logic [15:0]   addr_q, addr_d;
   logic          rd_q, rd_d, we_q, we_d;
   logic [7:0]    dout_q, dout_d;

   assign rise         = dma_start & ~start_q;
   assign busy         = st_q != IDLE;
   assign bus.busrq_n  = !(st_q inside {REQ, COPY, FLUSH});
   // gated so a read strobe can never overlap a withdrawn acknowledge
   assign bus.dma_rd   = rd_q & ~bus.busak_n;
   assign bus.dma_addr = addr_q;
   assign bus.obj_addr = oaddr_q;
   assign bus.obj_dout = dout_q;
   assign bus.obj_we   = we_q;

   always_comb begin
      st_d    = st_q;
      pend_d  = pend_q | (rise & (st_q != IDLE));
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      we_d    = 1'b0;
      oaddr_d = oaddr_q;
      dout_d  = dout_q;
      case (st_q)
         IDLE: if (rise || pend_q) begin
            st_d   = REQ;
            pend_d = 1'b0;
         end
         REQ: if (cen && !bus.busak_n) begin
            st_d  = COPY;
            cnt_d = '0;
         end
         COPY, FLUSH: if (bus.busak_n) begin
            st_d = REL;
            rd_d = 1'b0;
         end else if (cen) begin
            // byte for the previous address arrives now; counter wraps to 0 in FLUSH so cnt-1 is LEN-1
            if (st_q == FLUSH || cnt_q != '0) begin
               we_d    = 1'b1;
               oaddr_d = cnt_q - AW'(1);
               dout_d  = bus.dma_din;
            end
            if (st_q == COPY) begin
               addr_d = SRC_BASE + 16'(cnt_q);
               rd_d   = 1'b1;
               cnt_d  = cnt_q + AW'(1);
               st_d   = cnt_q == AW'(LEN - 1) ? FLUSH : COPY;
            end else begin
               rd_d = 1'b0;
               st_d = REL;
            end
         end
         REL: if (cen && bus.busak_n) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st_q    <= IDLE;
         start_q <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;
         oaddr_q <= '0;
         dout_q  <= '0;
      end else begin
         st_q    <= st_d;
         start_q <= dma_start;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         oaddr_q <= oaddr_d;
         dout_q  <= dout_d;
      end
endmodule

// File: tb/tb_jtpang_objdma.sv
// tb_jtpang_objdma: randomized scenarios against a memory/buffer reference model for the object DMA
module tb_jtpang_objdma;
   import jtpang_objdma_pkg::*;
   localparam int LEN = 512;
   localparam int AW  = 9;

   logic clk = 0, rst_n = 0, cen = 0, start0 = 0, start1 = 0, force0 = 0;
   logic busy0, busy1;
   logic [1:0] div = 0, akp0 = 2'b11, akp1 = 2'b11;
   logic [7:0] mem [0:65535];
   logic [7:0] buf0 [0:LEN-1];
   logic [7:0] buf1 [0:LEN-1];
   logic [15:0] addrq0[$], addrq1[$];
   int errors = 0, checks = 0, cyc = 0;
   int we0 = 0, we1 = 0, req0 = 0, earlyreq0 = 0, rdbad0 = 0, rdany0 = 0, t_rd0 = 0, t_rel0 = 0, last0 = -1;
   logic prq0 = 1, prd0 = 0;

   jtpang_objdma_if #(.AW(AW)) b0();
   jtpang_objdma_if #(.AW(AW)) b1();

   jtpang_objdma #(.SRC_BASE(16'hE000), .LEN(LEN)) dut0 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .dma_start(start0), .busy(busy0), .bus(b0));
   jtpang_objdma #(.SRC_BASE(16'hFF00), .LEN(LEN)) dut1 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .dma_start(start1), .busy(busy1), .bus(b1));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      div <= div + 2'd1;
      cen <= div == 2'd2;
   end

   // Z80 acknowledges two cens after the request changes
   always @(posedge clk) if (cen) begin
      akp0 <= {akp0[0], b0.busrq_n};
      akp1 <= {akp1[0], b1.busrq_n};
   end
   assign b0.busak_n = force0 | akp0[1];
   assign b1.busak_n = akp1[1];
   assign b0.dma_din = mem[b0.dma_addr];
   assign b1.dma_din = mem[b1.dma_addr];

   always @(posedge clk) begin
      cyc++;
      if (b0.obj_we) begin buf0[b0.obj_addr] = b0.obj_dout; we0++; last0 = int'(b0.obj_addr); end
      if (b1.obj_we) begin buf1[b1.obj_addr] = b1.obj_dout; we1++; end
      if (cen && b0.dma_rd) addrq0.push_back(b0.dma_addr);
      if (cen && b1.dma_rd) addrq1.push_back(b1.dma_addr);
      if (b0.dma_rd) rdany0++;
      if (b0.dma_rd && b0.busak_n) rdbad0++;
      if (prq0 && !b0.busrq_n) begin req0++; if (!b0.busak_n) earlyreq0++; end
      if (!prq0 && b0.busrq_n) t_rel0 = cyc;
      if (!prd0 && b0.dma_rd) t_rd0 = cyc;
      prq0 = b0.busrq_n;
      prd0 = b0.dma_rd;
   end

   task automatic clear_log;
      we0 = 0; we1 = 0; req0 = 0; earlyreq0 = 0; rdbad0 = 0; rdany0 = 0; last0 = -1;
      addrq0.delete(); addrq1.delete();
      for (int i = 0; i < LEN; i++) begin buf0[i] = 'x; buf1[i] = 'x; end
   endtask

   task automatic pulse(input int inst);
      @(negedge clk);
      if (inst == 0) start0 = 1; else start1 = 1;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      start0 = 0; start1 = 0;
   endtask

   task automatic wait_busy(input int inst, input logic v, input int budget, output logic ok);
      ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         ok = ((inst == 0) ? busy0 : busy1) === v;
      end
   endtask

   task automatic test_reset;
      repeat (6) @(negedge clk);
      checks++;
      if ({b0.busrq_n, b0.dma_rd, b0.obj_we, busy0} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctrl got={busrq_n,rd,we,busy}=%b exp=1000", {b0.busrq_n, b0.dma_rd, b0.obj_we, busy0});
      end
      checks++;
      if (b0.dma_addr !== 16'h0) begin errors++; $display("FAIL reset_dma_addr got=%h exp=0000", b0.dma_addr); end
      checks++;
      if ({b0.obj_addr, b0.obj_dout} !== 17'h0) begin
         errors++; $display("FAIL reset_obj got addr=%h dout=%h exp=0", b0.obj_addr, b0.obj_dout);
      end
      rst_n = 1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_basic;
      logic ok;
      int bad = 0, own;
      clear_log();
      repeat ($urandom_range(0, 7)) @(negedge clk);
      pulse(0);
      wait_busy(0, 1'b0, 6000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done got=timeout exp=idle"); end
      checks++; if (we0 !== LEN) begin errors++; $display("FAIL basic_we_count got=%0d exp=%0d", we0, LEN); end
      checks++; if (addrq0.size() !== LEN) begin errors++; $display("FAIL basic_rd_count got=%0d exp=%0d", addrq0.size(), LEN); end
      for (int i = 0; i < addrq0.size(); i++) if (addrq0[i] !== 16'(32'hE000 + i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_addr got=%0d bad exp=0", bad); end
      bad = 0;
      for (int i = 0; i < LEN; i++) if (buf0[i] !== (8'(i) ^ 8'h5A)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_data got=%0d bad exp=0", bad); end
      own = (t_rel0 - t_rd0) / 4 + 1;
      checks++; if (own !== LEN + 1) begin errors++; $display("FAIL basic_own got=%0d exp=%0d", own, LEN + 1); end
      checks++; if (rdbad0 !== 0) begin errors++; $display("FAIL basic_rd_no_ack got=%0d exp=0", rdbad0); end
   endtask

   task automatic test_back_to_back;
      logic ok = 0;
      int bad = 0, at = $urandom_range(5, 300);
      clear_log();
      pulse(0);
      for (int n = 0; n < 3000 && we0 < at; n++) @(negedge clk);
      pulse(0);
      repeat ($urandom_range(1, 10)) @(negedge clk);
      pulse(0);
      for (int n = 0; n < 6000 && !ok; n++) begin @(negedge clk); ok = req0 == 2; end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_req got=%0d reqs exp=2", req0); end
      wait_busy(0, 1'b0, 6000, ok);
      repeat (200) @(negedge clk);
      checks++; if (req0 !== 2) begin errors++; $display("FAIL b2b_req_count got=%0d exp=2", req0); end
      checks++; if (we0 !== 2 * LEN) begin errors++; $display("FAIL b2b_we_count got=%0d exp=%0d", we0, 2 * LEN); end
      checks++; if (earlyreq0 !== 0) begin errors++; $display("FAIL b2b_req_before_release got=%0d exp=0", earlyreq0); end
      for (int i = 0; i < LEN; i++) if (buf0[i] !== mem[16'hE000 + i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_data got=%0d bad exp=0", bad); end
   endtask

   task automatic test_wrap;
      logic ok;
      int bad = 0;
      clear_log();
      pulse(1);
      wait_busy(1, 1'b0, 6000, ok);
      checks++; if (ok !== 1'b1 || we1 !== LEN) begin errors++; $display("FAIL wrap_done got we=%0d ok=%b exp=%0d", we1, ok, LEN); end
      for (int i = 0; i < addrq1.size(); i++) if (addrq1[i] !== 16'((32'hFF00 + i) % 65536)) bad++;
      checks++; if (bad !== 0 || addrq1.size() !== LEN) begin errors++; $display("FAIL wrap_addr got=%0d bad size=%0d exp=0", bad, addrq1.size()); end
      checks++;
      if (addrq1.size() != LEN || addrq1[255] !== 16'hFFFF || addrq1[256] !== 16'h0000) begin
         errors++; $display("FAIL wrap_edge got size=%0d exp FFFF then 0000", addrq1.size());
      end
      bad = 0;
      for (int i = 0; i < LEN; i++) if (buf1[i] !== mem[(32'hFF00 + i) % 65536]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_data got=%0d bad exp=0", bad); end
   endtask

   task automatic test_reset_mid;
      logic ok = 0;
      int snap;
      clear_log();
      pulse(0);
      for (int n = 0; n < 3000 && !ok; n++) begin @(negedge clk); ok = addrq0.size() >= 100; end
      rst_n = 0;
      #1;
      checks++;
      if ({b0.busrq_n, busy0, b0.dma_rd} !== 3'b100) begin
         errors++; $display("FAIL rstmid_async got={busrq_n,busy,rd}=%b exp=100", {b0.busrq_n, busy0, b0.dma_rd});
      end
      snap = we0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (300) @(negedge clk);
      checks++; if (we0 !== snap) begin errors++; $display("FAIL rstmid_no_we got=%0d exp=%0d", we0, snap); end
      checks++; if ({busy0, b0.busrq_n, req0 == 1} !== 3'b011) begin
         errors++; $display("FAIL rstmid_idle got busy=%b busrq_n=%b reqs=%0d exp idle, 1 req", busy0, b0.busrq_n, req0);
      end
   endtask

   task automatic test_abort;
      logic ok = 0;
      int snap;
      clear_log();
      pulse(0);
      for (int n = 0; n < 3000 && !ok; n++) begin @(negedge clk); ok = b0.dma_rd && b0.dma_addr == 16'hE032; end
      force0 = 1;
      @(posedge clk);
      @(negedge clk);
      snap = we0;
      wait_busy(0, 1'b0, 300, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_idle got=busy exp=idle"); end
      checks++; if (last0 > 49 || we0 !== snap) begin errors++; $display("FAIL abort_last_we got addr=%0d we=%0d exp<=49 we=%0d", last0, we0, snap); end
      checks++; if (rdbad0 !== 0) begin errors++; $display("FAIL abort_rd_no_ack got=%0d exp=0", rdbad0); end
      force0 = 0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_hold;
      logic ok;
      int rqhigh = 0;
      clear_log();
      force0 = 1;
      pulse(0);
      for (int n = 0; n < 40000; n++) begin @(negedge clk); if (b0.busrq_n) rqhigh++; end
      checks++; if (rqhigh !== 0 || busy0 !== 1'b1) begin errors++; $display("FAIL hold_req got high=%0d busy=%b exp=0,1", rqhigh, busy0); end
      checks++; if (rdany0 !== 0 || we0 !== 0) begin errors++; $display("FAIL hold_quiet got rd=%0d we=%0d exp=0,0", rdany0, we0); end
      force0 = 0;
      wait_busy(0, 1'b0, 6000, ok);
      checks++; if (ok !== 1'b1 || we0 !== LEN) begin errors++; $display("FAIL hold_resume got we=%0d ok=%b exp=%0d", we0, ok, LEN); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < LEN; i++) mem[16'hE000 + i] = 8'(i) ^ 8'h5A;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_abort();
      test_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jtpang_objdma.md
JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

Interface
REQ-001 SHALL have parameter SRC_BASE, default 16'hE000, meaning first main-bus byte address copied.
REQ-002 SHALL have parameter LEN, default 512, meaning bytes per transfer (power of two, 2..4096).
REQ-003 SHALL have clk  input  1  sole clock.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have cen  input  1  CPU clock enable; paces all bus activity.
REQ-006 SHALL have dma_start  input  1  level from the decoded I/O port 6 access; a rising edge requests a transfer.
REQ-007 SHALL have busrq_n  output  1  Z80 bus request, active-low.
REQ-008 SHALL have busak_n  input  1  Z80 bus acknowledge, active-low.
REQ-009 SHALL have dma_addr  output  16  main-bus address driven while the bus is owned.
REQ-010 SHALL have dma_rd  output  1  high while dma_addr is valid.
REQ-011 SHALL have dma_din  input  8  byte read from the main bus, valid one cen after its address.
REQ-012 SHALL have obj_addr  output  log2(LEN)  object buffer write address.
REQ-013 SHALL have obj_dout  output  8  object buffer write data.
REQ-014 SHALL have obj_we  output  1  object buffer write strobe, one clk wide.
REQ-015 SHALL have busy  output  1  high from accepted request until bus release.

Function
REQ-016 SHALL register dma_start and detect its rising edge on clk (not gated by cen).
REQ-017 SHALL implement states IDLE, REQ, COPY, FLUSH, REL.
REQ-018 IDLE: on edge or pending flag -> REQ, clear pending, busrq_n low on the next clk.
REQ-019 REQ: hold busrq_n low; on a cen with busak_n low -> COPY, counter = 0; no timeout.
REQ-020 COPY: on each cen drive dma_addr = SRC_BASE + counter (16-bit wrap at FFFF->0000), dma_rd = 1, increment counter.
REQ-021 Pipeline: on each cen in COPY after the first and in FLUSH, capture dma_din into obj_dout, obj_addr = counter-1 of previous cen, pulse obj_we for that clk only.
REQ-022 COPY -> FLUSH on the cen issuing address LEN-1; FLUSH writes the last byte on its cen, dma_rd = 0, -> REL.
REQ-023 REL: busrq_n high on the same clk; -> IDLE when busak_n seen high on a cen.
REQ-024 Total bus ownership SHALL be exactly LEN+1 cen periods from first address to busrq_n release.
REQ-025 Edge while not IDLE SHALL set a one-deep pending flag; further edges are dropped; pending starts a new transfer on return to IDLE.
REQ-026 If busak_n rises during COPY/FLUSH (protocol error), block SHALL abort to REL, no further obj_we.
REQ-027 obj_we SHALL never assert outside COPY/FLUSH; dma_rd SHALL never assert while busak_n is high.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 On rst_n low, asynchronously: state IDLE, busrq_n 1, dma_rd 0, obj_we 0, busy 0, dma_addr 0, obj_addr 0, obj_dout 0, counter 0, pending 0, edge register 0.
REQ-030 Reset mid-transfer SHALL release the bus immediately; no transfer resumes after reset.

Structure
REQ-031 State encoding and default SRC_BASE/LEN SHALL live in package jtpang_objdma_pkg.
REQ-032 Single module; no sub-module (edge detect and counter are inline).

Verification
REQ-033 cen every 4 clk, busak_n follows busrq_n after 2 cen, RAM E000+i = i^8'h5A -> buffer[i] = i^5A for i=0..511, 513 cens of ownership.
REQ-034 Two start edges during COPY -> exactly two transfers total, second starts after busrq_n returns high.
REQ-035 SRC_BASE = 16'hFF00, LEN = 512 -> addresses FF00..FFFF then 0000..00FF.
REQ-036 rst_n low at counter 100 -> busrq_n high asynchronously, no obj_we afterwards, IDLE after release.
REQ-037 busak_n forced high at counter 50 -> REL, last obj_we at addr <= 49, busy clears.
REQ-038 busak_n held high 10000 cen -> busrq_n stays low, zero dma_rd/obj_we.
